apb_master: RTL and testbench

- APB3 requester that sits directly upstream of the APB slave stage.
- Accepts single read/write commands on a valid/ready request port and runs the IDLE/SETUP/ACCESS bus sequence on psel/penable.
- Honours pready wait states, captures prdata and pslverr, and returns one response pulse per command.
- A programmable wait-state timeout keeps a hung slave from stalling the requester forever.

---
 rtl/apb_master.sv | 83 ++++++++
 tb/tb_apb_master.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// apb_master: APB3 requester turning valid/ready commands into SETUP/ACCESS bus transfers with a wait-state timeout
module apb_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt;
  logic          done, tmo;
  assign req_ready = state_q == IDLE;
  // next state plus completion/timeout decode for the current ACCESS edge
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE:    state_d = req_valid ? SETUP : IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        done    = pready;
        tmo     = !pready && TIMEOUT_CYCLES > 0 && cnt == TMAX;
        state_d = (done || tmo) ? IDLE : ACCESS;
      end
      default: state_d = IDLE;
    endcase
  end
  // registered bus signals, wait counter and response; counter frozen when timeout is disabled so it never wraps
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q     <= IDLE;
      cnt         <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel      <= state_d != IDLE;
      penable   <= state_d == ACCESS;
      cnt       <= state_q == SETUP ? '0 :
                   (state_q == ACCESS && !pready && TIMEOUT_CYCLES > 0) ? cnt + CW'(1) : cnt;
      rsp_valid <= done || tmo;
      if (state_q == IDLE && req_valid) begin
        pwrite <= req_write;
        paddr  <= req_addr;
        pwdata <= req_wdata;
      end
      if (done || tmo) begin
        rsp_rdata   <= (tmo || pwrite) ? '0 : prdata;
        rsp_err     <= tmo || pslverr;
        rsp_timeout <= tmo;
      end
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: table-driven, hand-written and randomized checks of apb_master against a transaction-level model
module tb_apb_master;
  localparam int TO = 16;
  logic        pclk = 0, presetn = 0;
  logic        req_valid = 0, req_write = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata = 0;
  logic        pready = 0, pslverr = 0;
  int total = 0, bad = 0;

  apb_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic w; logic [31:0] a; logic [31:0] d; int waits; logic [31:0] rd; logic se;
    logic [31:0] e_rdata; logic e_err; logic e_to; int e_acc;
  } vec_t;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  // transaction-level model: a transfer either finishes on the first ready cycle or gives up after TO cycles
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.e_to    = (TO > 0) && (v.waits >= TO);
    r.e_acc   = r.e_to ? TO : v.waits + 1;
    r.e_rdata = (r.e_to || v.w) ? 32'h0 : v.rd;
    r.e_err   = r.e_to || v.se;
    return r;
  endfunction

  // entered just after a falling edge with the DUT idle
  task automatic xfer(input vec_t v);
    int acc;
    chk("idle_ready", {31'b0, req_ready}, 32'h1);
    req_valid = 1; req_write = v.w; req_addr = v.a; req_wdata = v.d;
    @(negedge pclk);
    req_valid = $urandom_range(0, 1); req_write = $urandom; req_addr = $urandom; req_wdata = $urandom;
    chk("setup_psel_pen", {30'b0, psel, penable}, 32'h2);
    chk("setup_ready", {31'b0, req_ready}, 32'h0);
    chk("setup_paddr", paddr, v.a);
    @(negedge pclk);
    acc = 0;
    while (psel && penable && acc < 200) begin
      acc++;
      pready  = (acc == v.waits + 1);
      prdata  = pready ? v.rd : $urandom;
      pslverr = pready ? v.se : 1'($urandom);
      chk("access_bus", {paddr ^ pwdata, 30'b0, pwrite, req_ready}, {v.a ^ v.d, 30'b0, v.w, 1'b0});
      req_addr = $urandom; req_wdata = $urandom; req_write = $urandom;
      @(negedge pclk);
    end
    pready = 0; pslverr = 0; req_valid = 0;
    chk("access_cycles", acc, v.e_acc);
    chk("rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("rsp_rdata", rsp_rdata, v.e_rdata);
    chk("rsp_err_to", {30'b0, rsp_err, rsp_timeout}, {30'b0, v.e_err, v.e_to});
    chk("end_psel_ready", {30'b0, psel, req_ready}, 32'h1);
    @(negedge pclk);
    chk("rsp_pulse_end", {31'b0, rsp_valid}, 32'h0);
    chk("rsp_hold", {rsp_rdata[29:0], rsp_err, rsp_timeout}, {v.e_rdata[29:0], v.e_err, v.e_to});
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    int acc_q[$], rsp_i[$];
    logic [31:0] rsp_q[$];
    tbl[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 0,    32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1};
    tbl[1] = '{1'b0, 32'h24, 32'h0,        3,    32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 4};
    tbl[2] = '{1'b1, 32'h30, 32'h1234,     1,    32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 2};
    tbl[3] = '{1'b0, 32'h40, 32'h0,        1000, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b1, 1'b1, 16};
    tbl[4] = '{1'b0, 32'h44, 32'h0,        15,   32'h0BADF00D, 1'b0, 32'h0BADF00D, 1'b0, 1'b0, 16};
    tbl[5] = '{1'b0, 32'h48, 32'h0,        2,    32'h5555,     1'b1, 32'h5555,     1'b1, 1'b0, 3};
    repeat (2) @(negedge pclk);
    chk("rst_outputs", {paddr | pwdata | rsp_rdata}, 32'h0);
    chk("rst_flags", {25'b0, psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, req_ready}, 32'h1);
    presetn = 1;
    @(negedge pclk);
    foreach (tbl[i]) xfer(tbl[i]);
    // reset during the second ACCESS wait cycle drops the transfer silently
    req_valid = 1; req_write = 0; req_addr = 32'h80;
    @(negedge pclk);
    req_valid = 0;
    @(negedge pclk);
    pready = 0;
    @(negedge pclk);
    presetn = 0;
    @(negedge pclk);
    chk("rst_mid_bus", {29'b0, psel, penable, req_ready}, 32'h1);
    chk("rst_mid_rsp", {31'b0, rsp_valid}, 32'h0);
    presetn = 1;
    @(negedge pclk);
    chk("rst_mid_norsp", {31'b0, rsp_valid}, 32'h0);
    xfer(model('{1'b1, 32'h84, 32'hCAFEF00D, 1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 0}));
    // back-to-back commands with req_valid held high
    pready = 1; prdata = 32'h12345678;
    for (int i = 0; i < 12; i++) begin
      case (acc_q.size())
        0: begin req_valid = 1; req_write = 1; req_addr = 32'h0; req_wdata = 32'h1; end
        1: begin req_valid = 1; req_write = 0; req_addr = 32'h4; req_wdata = 32'h0; end
        default: begin req_valid = 0; req_addr = 32'hFFF0; end
      endcase
      if (psel) chk("b2b_paddr", paddr, acc_q.size() == 1 ? 32'h0 : 32'h4);
      if (rsp_valid) begin rsp_q.push_back(rsp_rdata); rsp_i.push_back(i); end
      if (req_ready && req_valid) acc_q.push_back(i);
      @(negedge pclk);
    end
    pready = 0;
    chk("b2b_accepts", acc_q.size(), 2);
    chk("b2b_rsps", rsp_q.size(), 2);
    if (acc_q.size() == 2 && rsp_q.size() == 2) begin
      chk("b2b_spacing", acc_q[1] - acc_q[0], 3);
      chk("b2b_rsp0_lat", rsp_i[0] - acc_q[0], 3);
      chk("b2b_rsp1_lat", rsp_i[1] - acc_q[1], 3);
      chk("b2b_rsp0", rsp_q[0], 32'h0);
      chk("b2b_rsp1", rsp_q[1], 32'h12345678);
    end
    // randomized transfers against the model
    for (int i = 0; i < 40; i++) begin
      v.w = $urandom_range(0, 1); v.a = $urandom; v.d = $urandom;
      v.waits = $urandom_range(0, 20); v.rd = $urandom; v.se = $urandom_range(0, 1);
      xfer(model(v));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
